// File: rtl/onchip_mem_arbiter_if.sv
// One requester port of the on-chip memory arbiter: request, write data and
// the accept/response strobes returned to that requester.
interface onchip_mem_arbiter_if #(
    parameter int AW = 17
) ();
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [3:0]    byteenable;
    logic [31:0]   writedata;
    logic          waitrequest;
    logic [31:0]   readdata;
    logic          readdatavalid;
    logic          error;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid, error
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid, error
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM with one-cycle
// read latency; out-of-range accesses are accepted, never issued, and flagged.
module onchip_mem_arbiter #(
    parameter int unsigned DEPTH = 98304,
    parameter int unsigned AW    = 17
) (
    input  logic                  clk,
    input  logic                  reset_n,
    onchip_mem_arbiter_if.slave   m0,
    onchip_mem_arbiter_if.slave   m1,
    input  logic                  hold,
    output logic [AW-1:0]         mem_address,
    output logic [3:0]            mem_byteenable,
    output logic [31:0]           mem_writedata,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    input  logic [31:0]           mem_readdata
);

    logic          req0, req1, win1, grant, win_wr, in_range;
    logic [AW-1:0] win_addr;
    logic [31:0]   rd_data;
    logic          rd_done;

    logic last_grant_q, last_grant_d;
    logic rsp_valid_q,  rsp_valid_d;
    logic rsp_owner_q,  rsp_owner_d;
    logic rsp_read_q,   rsp_read_d;
    logic rsp_oob_q,    rsp_oob_d;

    // Port 1 wins when alone or when port 0 held the bus last time.
    always_comb begin
        req0     = m0.read | m0.write;
        req1     = m1.read | m1.write;
        win1     = req1 && (!req0 || !last_grant_q);
        grant    = reset_n && !hold && (req0 || req1);
        win_addr = win1 ? m1.address : m0.address;
        win_wr   = win1 ? m1.write   : m0.write;
        in_range = 32'(win_addr) < DEPTH;

        m0.waitrequest = !(grant && !win1);
        m1.waitrequest = !(grant && win1);

        mem_chipselect = grant && in_range;
        mem_write      = grant && in_range && win_wr;
        mem_address    = grant ? win_addr : '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (grant) begin
            mem_byteenable = win1 ? m1.byteenable : m0.byteenable;
            mem_writedata  = win1 ? m1.writedata  : m0.writedata;
        end
    end

    always_comb begin
        last_grant_d = grant ? win1 : last_grant_q;
        rsp_valid_d  = grant;
        rsp_owner_d  = win1;
        rsp_read_d   = !win_wr;
        rsp_oob_d    = !in_range;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_owner_q  <= 1'b0;
            rsp_read_q   <= 1'b0;
            rsp_oob_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_owner_q  <= rsp_owner_d;
            rsp_read_q   <= rsp_read_d;
            rsp_oob_q    <= rsp_oob_d;
        end
    end

    // The registered tag steers this cycle's RAM output to the port granted last cycle.
    always_comb begin
        rd_done = rsp_valid_q && rsp_read_q;
        rd_data = rsp_oob_q ? '0 : mem_readdata;

        m0.readdatavalid = rd_done && !rsp_owner_q;
        m1.readdatavalid = rd_done && rsp_owner_q;
        m0.readdata      = (rd_done && !rsp_owner_q) ? rd_data : '0;
        m1.readdata      = (rd_done && rsp_owner_q)  ? rd_data : '0;
        m0.error         = rsp_valid_q && rsp_oob_q && !rsp_owner_q;
        m1.error         = rsp_valid_q && rsp_oob_q && rsp_owner_q;
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: a RAM environment, a per-cycle reference model
// and directed scenarios with literal expectations.
module tb_onchip_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        hold;
    logic [16:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_readdata;

    onchip_mem_arbiter_if #(.AW(17)) i0 ();
    onchip_mem_arbiter_if #(.AW(17)) i1 ();

    onchip_mem_arbiter #(.DEPTH(98304), .AW(17)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (i0),
        .m1             (i1),
        .hold           (hold),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_readdata   (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: registered address, unregistered data out.
    bit [31:0] ram [0:131071];
    bit [16:0] ram_addr_q;
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            ram_addr_q <= mem_address;
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    int unsigned n_cmp_m = 0, n_err_m = 0, n_cmp_d = 0, n_err_d = 0;

    // Reference model state
    bit [31:0] mdl_mem [0:131071];
    int        mdl_last = 1;
    bit        pend_v, pend_rd, pend_oob;
    int        pend_port;
    bit [31:0] pend_data;

    // Observations for the directed checks
    int        gl[$];
    bit [31:0] last_rd0, last_rd1;

    always @(negedge clk) begin
        bit r0, r1, g, w1, wr, inr;
        bit [16:0] a;
        bit [3:0]  be;
        bit [31:0] wd, word;
        bit e_rdv0, e_rdv1, e_err0, e_err1;
        bit [31:0] e_rd0, e_rd1;

        r0 = i0.read | i0.write;
        r1 = i1.read | i1.write;
        if (!reset_n) begin
            pend_v   = 1'b0;
            mdl_last = 1;
        end
        g  = reset_n && !hold && (r0 || r1);
        w1 = (r0 && r1) ? (mdl_last == 0) : r1;
        a  = w1 ? i1.address    : i0.address;
        be = w1 ? i1.byteenable : i0.byteenable;
        wd = w1 ? i1.writedata  : i0.writedata;
        wr = w1 ? i1.write      : i0.write;
        inr = 32'(a) < 32'd98304;

        e_rdv0 = pend_v && pend_rd && pend_port == 0;
        e_rdv1 = pend_v && pend_rd && pend_port == 1;
        e_err0 = pend_v && pend_oob && pend_port == 0;
        e_err1 = pend_v && pend_oob && pend_port == 1;
        e_rd0  = e_rdv0 ? pend_data : 32'h0;
        e_rd1  = e_rdv1 ? pend_data : 32'h0;

        chk_m("m0_waitrequest",   32'(i0.waitrequest),   32'(!(g && !w1)));
        chk_m("m1_waitrequest",   32'(i1.waitrequest),   32'(!(g && w1)));
        chk_m("m0_readdatavalid", 32'(i0.readdatavalid), 32'(e_rdv0));
        chk_m("m1_readdatavalid", 32'(i1.readdatavalid), 32'(e_rdv1));
        chk_m("m0_readdata",      i0.readdata,           e_rd0);
        chk_m("m1_readdata",      i1.readdata,           e_rd1);
        chk_m("m0_error",         32'(i0.error),         32'(e_err0));
        chk_m("m1_error",         32'(i1.error),         32'(e_err1));
        chk_m("mem_chipselect",   32'(mem_chipselect),   32'(g && inr));
        chk_m("mem_write",        32'(mem_write),        32'(g && inr && wr));
        chk_m("mem_address",      32'(mem_address),      g ? 32'(a) : 32'h0);
        chk_m("mem_byteenable",   32'(mem_byteenable),   g ? 32'(be) : 32'h0);
        chk_m("mem_writedata",    mem_writedata,         g ? wd : 32'h0);

        if (i0.readdatavalid) last_rd0 = i0.readdata;
        if (i1.readdatavalid) last_rd1 = i1.readdata;
        if (!i0.waitrequest) gl.push_back(0);
        else if (!i1.waitrequest) gl.push_back(1);

        if (g) begin
            pend_v    = 1'b1;
            pend_port = w1 ? 1 : 0;
            pend_rd   = !wr;
            pend_oob  = !inr;
            pend_data = inr ? mdl_mem[a] : 32'h0;
            if (inr && wr) begin
                word = mdl_mem[a];
                for (int b = 0; b < 4; b++)
                    if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
                mdl_mem[a] = word;
            end
            mdl_last = w1 ? 1 : 0;
        end else begin
            pend_v = 1'b0;
        end
    end

    task automatic chk_m(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp_m++;
        if (act !== exp) begin
            n_err_m++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp_d++;
        if (act !== exp) begin
            n_err_d++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input int p, input bit rd, input bit wr, input logic [16:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        if (p == 0) begin
            i0.read = rd; i0.write = wr; i0.address = a; i0.byteenable = be; i0.writedata = d;
        end else begin
            i1.read = rd; i1.write = wr; i1.address = a; i1.byteenable = be; i1.writedata = d;
        end
    endtask

    task automatic access(input int p, input bit wr, input logic [16:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        bit acc;
        acc = 1'b0;
        drive(p, !wr, wr, a, be, d);
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = (p == 0) ? !i0.waitrequest : !i1.waitrequest;
            @(posedge clk); #1;
        end
        drive(p, 1'b0, 1'b0, '0, '0, '0);
        chk_d("access_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int s;
        reset_n = 1'b0;
        hold    = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);

        @(negedge clk);
        chk_d("rst_m0_waitrequest", 32'(i0.waitrequest), 32'd1);
        chk_d("rst_m1_waitrequest", 32'(i1.waitrequest), 32'd1);
        chk_d("rst_mem_chipselect", 32'(mem_chipselect), 32'd0);
        idle(2);
        reset_n = 1'b1;

        // Write then read back on port 0
        access(0, 1'b1, 17'h10, 4'hF, 32'hA5A5_0001);
        access(0, 1'b0, 17'h10, 4'h0, 32'h0);
        @(negedge clk);
        chk_d("p0_rd_valid", 32'(i0.readdatavalid), 32'd1);
        chk_d("p0_rd_data",  i0.readdata, 32'hA5A5_0001);

        // Byte-lane merge on port 1
        idle(1);
        access(1, 1'b1, 17'h20, 4'hF, 32'h1234_5678);
        access(1, 1'b1, 17'h20, 4'b0010, 32'hFFFF_FFFF);
        access(1, 1'b0, 17'h20, 4'h0, 32'h0);
        @(negedge clk);
        chk_d("p1_be_merge", i1.readdata, 32'h1234_FF78);

        // Out-of-range read and write
        idle(1);
        drive(0, 1'b1, 1'b0, 17'd98304, 4'h0, 32'h0);
        @(negedge clk);
        chk_d("oob_rd_accept", 32'(i0.waitrequest), 32'd0);
        chk_d("oob_rd_cs",     32'(mem_chipselect), 32'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk_d("oob_rd_error", 32'(i0.error), 32'd1);
        chk_d("oob_rd_valid", 32'(i0.readdatavalid), 32'd1);
        chk_d("oob_rd_data",  i0.readdata, 32'h0);
        idle(1);
        access(1, 1'b1, 17'h1FFFF, 4'hF, 32'hDEAD_BEEF);
        @(negedge clk);
        chk_d("oob_wr_error", 32'(i1.error), 32'd1);
        @(negedge clk);
        chk_d("oob_wr_error_pulse", 32'(i1.error), 32'd0);
        chk_d("oob_wr_mem_unchanged", ram[17'h1FFFF], 32'h0);

        // Continuous contention straight out of reset
        @(posedge clk); #1;
        reset_n = 1'b0;
        drive(0, 1'b1, 1'b0, 17'h10, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 17'h20, 4'h0, 32'h0);
        idle(2);
        s = gl.size();
        reset_n = 1'b1;
        idle(6);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        chk_d("alt_grant_count", 32'(gl.size() - s), 32'd6);
        if (gl.size() >= s + 4) begin
            chk_d("alt_grant0", 32'(gl[s]),   32'd0);
            chk_d("alt_grant1", 32'(gl[s+1]), 32'd1);
            chk_d("alt_grant2", 32'(gl[s+2]), 32'd0);
            chk_d("alt_grant3", 32'(gl[s+3]), 32'd1);
        end
        @(negedge clk);
        chk_d("alt_p0_data", last_rd0, 32'hA5A5_0001);
        chk_d("alt_p1_data", last_rd1, 32'h1234_FF78);

        // Hold with a read in flight and both ports requesting
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 17'h10, 4'h0, 32'h0);
        @(negedge clk);
        chk_d("hold_pre_grant", 32'(i0.waitrequest), 32'd0);
        @(posedge clk); #1;
        hold = 1'b1;
        drive(1, 1'b1, 1'b0, 17'h20, 4'h0, 32'h0);
        s = gl.size();
        @(negedge clk);
        chk_d("hold_inflight_valid", 32'(i0.readdatavalid), 32'd1);
        chk_d("hold_inflight_data",  i0.readdata, 32'hA5A5_0001);
        idle(4);
        @(negedge clk);
        chk_d("hold_no_grants", 32'(gl.size() - s), 32'd0);
        @(posedge clk); #1;
        hold = 1'b0;
        @(negedge clk);
        chk_d("hold_resume_m1", 32'(i1.waitrequest), 32'd0);
        chk_d("hold_resume_m0", 32'(i0.waitrequest), 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        idle(2);

        // Reset the cycle after a read grant
        drive(1, 1'b1, 1'b0, 17'h20, 4'h0, 32'h0);
        @(negedge clk);
        chk_d("rst_pre_grant", 32'(i1.waitrequest), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk_d("rst_discard_valid", 32'(i1.readdatavalid), 32'd0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 17'h10, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 17'h20, 4'h0, 32'h0);
        idle(1);
        reset_n = 1'b1;
        @(negedge clk);
        chk_d("post_rst_m0_wins", 32'(i0.waitrequest), 32'd0);
        chk_d("post_rst_m1_waits", 32'(i1.waitrequest), 32'd1);
        chk_d("post_rst_no_stale", 32'(i1.readdatavalid), 32'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp_m + n_cmp_d, n_err_m + n_err_d);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 The block SHALL take parameter DEPTH, default 98304, meaning the number of valid 32-bit words in the shared memory.
REQ-002 The block SHALL take parameter AW, default 17, meaning the word-address width.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 mN_address  in  AW  word address from requester N (N = 0, 1, same for all mN_ ports).
REQ-006 mN_read / mN_write  in  1 each  read/write request; held until accepted.
REQ-007 mN_byteenable  in  4  byte lanes for writes.
REQ-008 mN_writedata  in  32  write data.
REQ-009 mN_waitrequest  out  1  high = request not accepted this cycle.
REQ-010 mN_readdata  out  32  read data, valid with mN_readdatavalid.
REQ-011 mN_readdatavalid  out  1  one-cycle read-data strobe.
REQ-012 mN_error  out  1  one-cycle strobe flagging an out-of-range access.
REQ-013 hold  in  1  high = issue no new grants.
REQ-014 mem_address  out  AW  to single-port RAM.
REQ-015 mem_byteenable  out  4  to the RAM.
REQ-016 mem_writedata  out  32  to the RAM.
REQ-017 mem_chipselect / mem_write  out  1 each  to the RAM.
REQ-018 mem_readdata  in  32  from the RAM; address registered, output unregistered; data valid the cycle after issue.

Function
REQ-019 Requester N SHALL be requesting when mN_read | mN_write; if both are high, the access SHALL be treated as a write.
REQ-020 Arbitration SHALL be combinational each cycle: one requester wins alone; if both request, the one not equal to register last_grant wins.
REQ-021 last_grant SHALL update to the winner on every grant.
REQ-022 When hold=1 or reset_n=0, no grant SHALL occur.
REQ-023 The winner's mN_waitrequest SHALL be 0 in the grant cycle; every other port's waitrequest SHALL be 1.
REQ-024 In the grant cycle, mem_address/byteenable/writedata SHALL be muxed from the winner.
REQ-025 mem_write SHALL equal winner-is-write AND in-range.
REQ-026 mem_chipselect SHALL equal grant AND in-range, where in-range is address < DEPTH.
REQ-027 With no grant, mem_chipselect and mem_write SHALL be 0, and mem_address/byteenable/writedata SHALL be 0.
REQ-028 Read latency SHALL be exactly 1: the cycle after a read grant, the owner's readdatavalid=1 and readdata=mem_readdata (in-range) or 32'h0 (out-of-range).
REQ-029 An owner/read/oob tag SHALL be registered at grant to route that response.
REQ-030 Back-to-back grants SHALL be allowed every cycle, including alternating ports, giving one access per cycle throughput.
REQ-031 A response SHALL never be lost or misrouted when the next grant targets the other port.
REQ-032 Out-of-range accesses SHALL be accepted but not issued; mN_error SHALL pulse the cycle after grant (reads and writes).
REQ-033 An out-of-range write SHALL not modify memory.
REQ-034 When the port is idle, readdata SHALL be 0.
REQ-035 Responses already in flight SHALL complete when hold rises.
REQ-036 The bus arbitration logic SHALL hold no state other than last_grant and the one-stage response tag.

Reset
REQ-037 While reset_n=0, the block SHALL force all waitrequest=1, readdatavalid=0, error=0, readdata=0, mem_chipselect=0 and mem_write=0, and set last_grant=1 (port 0 wins the first contention).
REQ-038 A read in flight at reset SHALL be discarded (no readdatavalid after release).
REQ-039 The first grant SHALL be possible in the first clk edge with reset_n=1.

Verification
REQ-040 Port 0 writes 0xA5A5_0001 at address 0x10 with byteenable=4'hF, then reads 0x10 -> waitrequest low in each request cycle, readdatavalid 1 cycle after the read grant, readdata=0xA5A5_0001.
REQ-041 Both ports read continuously from reset -> grants alternate 0,1,0,1, one per cycle, each readdatavalid on the correct port with that port's data.
REQ-042 Port 1 writes 0xFFFF_FFFF with byteenable=4'b0010 over a word holding 0x1234_5678, then reads it -> 0x1234_FF78.
REQ-043 Port 0 reads address 98304 -> mem_chipselect=0, m0_error=1 and m0_readdata=0 with readdatavalid the next cycle; port 1 writes address 0x1FFFF -> m1_error pulse, memory unchanged.
REQ-044 hold=1 for 5 cycles with both requesting and one read in flight -> in-flight readdatavalid delivered, no grants for 5 cycles, arbitration resumes on the cycle hold falls.
REQ-045 reset_n pulled low the cycle after a read grant -> no readdatavalid; after release, under contention port 0 wins first.
